// File: rtl/cell_locator_if.sv
// cell_locator_if: scan position from the timing generator, grid location back to the colour mux.
interface cell_locator_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic [2:0] cell_col;
   logic [2:0] cell_row;
   logic [6:0] off_x;
   logic [6:0] off_y;
   logic in_grid;
   logic in_cell;
   logic in_border;
   logic sync_err;
   modport master(output hcount, vcount, input cell_col, cell_row, off_x, off_y, in_grid, in_cell, in_border, sync_err);
   modport slave(input hcount, vcount, output cell_col, cell_row, off_x, off_y, in_grid, in_cell, in_border, sync_err);
endinterface

// File: rtl/cell_locator.sv
// cell_locator: maps the live VGA scan position to grid cell, in-cell offset and border flag.
// Define CELL_LOCATOR_BORDER_EN to build the in_border comparators; otherwise in_border is 0.
module cell_locator #(
   parameter int GRID_X0 = 100,
   parameter int GRID_Y0 = 50,
   parameter int CELL = 94,
   parameter int GAP = 6,
   parameter int N_COLS = 4,
   parameter int N_ROWS = 4,
   parameter int BORDER = 2
) (
   input logic pixel_clk,
   input logic reset,
   cell_locator_if.slave bus
);
   typedef enum logic [1:0] {H_IDLE, H_ACTIVE, H_DONE} h_state_t;
   typedef enum logic [1:0] {V_IDLE, V_ACTIVE, V_DONE} v_state_t;
   localparam logic [10:0] X0 = 11'(GRID_X0);
   localparam logic [10:0] Y0 = 11'(GRID_Y0);
   localparam logic [6:0] PITCH_LAST = 7'(CELL + GAP - 1);
   localparam logic [6:0] CELL_LAST = 7'(CELL - 1);
   localparam logic [6:0] CELL_W = 7'(CELL);
   localparam logic [2:0] COL_LAST = 3'(N_COLS - 1);
   localparam logic [2:0] ROW_LAST = 3'(N_ROWS - 1);
   h_state_t h_state, h_next;
   v_state_t v_state, v_next;
   logic [6:0] xoff, xoff_next, yoff, yoff_next;
   logic [2:0] col, col_next, row, row_next;
   logic [10:0] prev_h;
   logic h_origin, jump, grid_next, cell_next, border_next;
   assign h_origin = bus.hcount == X0;
   assign jump = h_state == H_ACTIVE && !h_origin && bus.hcount != prev_h + 11'd1;
   always_comb begin
      h_next = h_state;
      xoff_next = xoff;
      col_next = col;
      if (h_origin) begin
         h_next = H_ACTIVE;
         xoff_next = '0;
         col_next = '0;
      end else if (jump) begin
         h_next = H_IDLE;
      end else if (h_state == H_ACTIVE) begin
         h_next = (col == COL_LAST && xoff == CELL_LAST) ? H_DONE : H_ACTIVE;
         xoff_next = (xoff == PITCH_LAST) ? '0 : xoff + 7'd1;
         col_next = (xoff == PITCH_LAST) ? col + 3'd1 : col;
      end else if (h_state == H_DONE && bus.hcount == '0) begin
         h_next = H_IDLE;
      end
   end
   // Vertical tracking advances once per line, on the hcount==0 cycle.
   always_comb begin
      v_next = v_state;
      yoff_next = yoff;
      row_next = row;
      if (bus.hcount == '0) begin
         if (bus.vcount == Y0) begin
            v_next = V_ACTIVE;
            yoff_next = '0;
            row_next = '0;
         end else if (v_state == V_ACTIVE) begin
            v_next = (row == ROW_LAST && yoff == CELL_LAST) ? V_DONE : V_ACTIVE;
            yoff_next = (yoff == PITCH_LAST) ? '0 : yoff + 7'd1;
            row_next = (yoff == PITCH_LAST) ? row + 3'd1 : row;
         end else if (v_state == V_DONE && bus.vcount == '0) begin
            v_next = V_IDLE;
         end
      end
   end
   assign grid_next = h_next == H_ACTIVE && v_next == V_ACTIVE;
   assign cell_next = grid_next && xoff_next < CELL_W && yoff_next < CELL_W;
`ifdef CELL_LOCATOR_BORDER_EN
   localparam logic [6:0] B_LO = 7'(BORDER);
   localparam logic [6:0] B_HI = 7'(CELL - BORDER);
   assign border_next = cell_next && (xoff_next < B_LO || xoff_next >= B_HI || yoff_next < B_LO || yoff_next >= B_HI);
`else
   assign border_next = 1'b0;
`endif
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         h_state <= H_IDLE;
         v_state <= V_IDLE;
         xoff <= '0;
         yoff <= '0;
         col <= '0;
         row <= '0;
         prev_h <= '0;
         bus.cell_col <= '0;
         bus.cell_row <= '0;
         bus.off_x <= '0;
         bus.off_y <= '0;
         bus.in_grid <= 1'b0;
         bus.in_cell <= 1'b0;
         bus.in_border <= 1'b0;
         bus.sync_err <= 1'b0;
      end else begin
         h_state <= h_next;
         v_state <= v_next;
         xoff <= xoff_next;
         yoff <= yoff_next;
         col <= col_next;
         row <= row_next;
         prev_h <= bus.hcount;
         bus.cell_col <= grid_next ? col_next : '0;
         bus.cell_row <= grid_next ? row_next : '0;
         bus.off_x <= grid_next ? xoff_next : '0;
         bus.off_y <= grid_next ? yoff_next : '0;
         bus.in_grid <= grid_next;
         bus.in_cell <= cell_next;
         bus.in_border <= border_next;
         bus.sync_err <= bus.sync_err | jump;
      end
   end
endmodule
